// File: rtl/traffic_req_gen_pkg.sv
// Shared types and defaults for the traffic-light request front-end.
// Imported by the channel sub-module and the top level.
package traffic_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } chan_state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_HOLD_MAX   = 200;
  localparam int DEF_CLR_CYCLES = 3;
  localparam int TIMER_W        = 8;
  localparam int DEB_CNT_W      = 4;

endpackage

// File: rtl/traffic_req_gen_if.sv
// Signal bundle between the pad ring / controller and the request front-end.
// master = the front-end itself, slave = the pads and controller around it.
interface traffic_req_gen_if;
  logic car_raw;
  logic ped_raw;
  logic svc_side;
  logic svc_ped;
  logic ctl_clr;
  logic req_side;
  logic req_ped;
  logic tmo_side;
  logic tmo_ped;

  modport master (
    input  car_raw, ped_raw, svc_side, svc_ped,
    output ctl_clr, req_side, req_ped, tmo_side, tmo_ped
  );

  modport slave (
    output car_raw, ped_raw, svc_side, svc_ped,
    input  ctl_clr, req_side, req_ped, tmo_side, tmo_ped
  );
endinterface

// File: rtl/traffic_req_gen_req_channel.sv
// One request channel: synchroniser, debouncer, IDLE/REQ/DONE FSM and hold timer.
// The rising-edge pulse leaves the module so the top can mask it during start-up clear.
module req_channel
  import traffic_req_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int HOLD_MAX   = DEF_HOLD_MAX
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_svc,
  input  logic i_edgeOk,
  output logic o_edge,
  output logic o_req,
  output logic o_tmo
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_deb;
  logic                 r_edge;
  logic [DEB_CNT_W-1:0] r_debCnt;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_tmo;
  chan_state_t          r_state;
  chan_state_t          w_nextState;
  logic                 w_tmoSet;

  // The level only flips after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_deb    <= 1'b0;
      r_edge   <= 1'b0;
      r_debCnt <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_debCnt <= '0;
        r_edge   <= 1'b0;
      end else if (r_debCnt == DEB_CNT_W'(DEB_CYCLES - 1)) begin
        r_deb    <= r_sync2;
        r_debCnt <= '0;
        r_edge   <= r_sync2;
      end else begin
        r_debCnt <= r_debCnt + 1'b1;
        r_edge   <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_timer <= (r_state == ST_REQ) ? r_timer + 1'b1 : '0;
      if (w_tmoSet) r_tmo <= 1'b1;
    end
  end

  // Service wins over a timeout landing on the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_tmoSet    = 1'b0;
    case (r_state)
      ST_IDLE: if (i_edgeOk && !i_svc) w_nextState = ST_REQ;
      ST_REQ: begin
        if (i_svc) begin
          w_nextState = ST_DONE;
        end else if (r_timer == TIMER_W'(HOLD_MAX - 1)) begin
          w_nextState = ST_IDLE;
          w_tmoSet    = 1'b1;
        end
      end
      ST_DONE: if (!i_svc) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign o_edge = r_edge;
  assign o_req  = (r_state == ST_REQ);
  assign o_tmo  = r_tmo;

endmodule

// File: rtl/traffic_req_gen.sv
// Request front-end top: start-up clear generator plus side and pedestrian channels.
// Edges arriving while the controller is still being cleared are discarded here.
module traffic_req_gen
  import traffic_req_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int HOLD_MAX   = DEF_HOLD_MAX,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input logic               CK,
  input logic               RN,
  traffic_req_gen_if.master bus
);

  logic [3:0] r_clrCnt;
  logic       r_clr;
  logic       w_sideEdge;
  logic       w_pedEdge;
  logic       w_sideEdgeOk;
  logic       w_pedEdgeOk;

  // Clear stays high for CLR_CYCLES edges after release, then never again until reset.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_clrCnt <= '0;
      r_clr    <= 1'b1;
    end else if (r_clr) begin
      if (r_clrCnt == 4'(CLR_CYCLES - 1)) r_clr <= 1'b0;
      else r_clrCnt <= r_clrCnt + 1'b1;
    end
  end

  assign w_sideEdgeOk = w_sideEdge & ~r_clr;
  assign w_pedEdgeOk  = w_pedEdge & ~r_clr;
  assign bus.ctl_clr  = r_clr;

  req_channel #(.DEB_CYCLES(DEB_CYCLES), .HOLD_MAX(HOLD_MAX)) u_side (
    .i_clk    (CK),
    .i_rst_n  (RN),
    .i_raw    (bus.car_raw),
    .i_svc    (bus.svc_side),
    .i_edgeOk (w_sideEdgeOk),
    .o_edge   (w_sideEdge),
    .o_req    (bus.req_side),
    .o_tmo    (bus.tmo_side)
  );

  req_channel #(.DEB_CYCLES(DEB_CYCLES), .HOLD_MAX(HOLD_MAX)) u_ped (
    .i_clk    (CK),
    .i_rst_n  (RN),
    .i_raw    (bus.ped_raw),
    .i_svc    (bus.svc_ped),
    .i_edgeOk (w_pedEdgeOk),
    .o_edge   (w_pedEdge),
    .o_req    (bus.req_ped),
    .o_tmo    (bus.tmo_ped)
  );

endmodule

// File: tb/tb_traffic_req_gen.sv
// Directed bench for traffic_req_gen: expected output changes are queued with their edge number,
// and a negedge monitor pops one entry each time the output vector changes.
module tb_traffic_req_gen;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int CLR  = 3;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } ev_t;

  logic CK = 1'b0;
  logic RN = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base;
  logic monEn = 1'b0;
  logic [4:0] prevVec = '0;
  logic [4:0] w_out;
  ev_t  sbQ[$];
  ev_t  popped;

  traffic_req_gen_if bus();

  traffic_req_gen #(
    .DEB_CYCLES (DEB),
    .HOLD_MAX   (HOLD),
    .CLR_CYCLES (CLR)
  ) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  // Vector order: ctl_clr, req_side, req_ped, tmo_side, tmo_ped
  assign w_out = {bus.ctl_clr, bus.req_side, bus.req_ped, bus.tmo_side, bus.tmo_ped};

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic car, input logic ped, input logic sS, input logic sP);
    bus.car_raw  = car;
    bus.ped_raw  = ped;
    bus.svc_side = sS;
    bus.svc_ped  = sP;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic expectAt(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    sbQ.push_back(e);
  endtask

  // Every change of the output vector must match the next queued event in edge and value.
  always @(negedge CK) begin
    if (monEn && (w_out !== prevVec)) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_event", int'(w_out), int'(prevVec));
      end else begin
        popped = sbQ.pop_front();
        checkOutput($sformatf("event_cycle_exp%0d", popped.cyc), cyc, popped.cyc);
        checkOutput($sformatf("event_value_at%0d", popped.cyc), int'(w_out), int'(popped.vec));
      end
    end
    prevVec = w_out;
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 RN = 1'b0;
    #2;
    checkOutput("reset_ctl_clr",  int'(bus.ctl_clr),  1);
    checkOutput("reset_req_side", int'(bus.req_side), 0);
    checkOutput("reset_req_ped",  int'(bus.req_ped),  0);
    checkOutput("reset_tmo_side", int'(bus.tmo_side), 0);
    checkOutput("reset_tmo_ped",  int'(bus.tmo_ped),  0);

    waitEdges(2);
    RN    = 1'b1;
    monEn = 1'b1;
    base  = cyc;
    expectAt(base + CLR, 5'b00000);
    waitEdges(5);

    $display("[TB] short glitch on car_raw");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(10);

    $display("[TB] side request served, then a second press from IDLE");
    for (int pass = 0; pass < 2; pass++) begin
      base = cyc;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      expectAt(base + 7, 5'b01000);
      waitEdges(9);
      base = cyc;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      expectAt(base + 1, 5'b00000);
      waitEdges(3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      waitEdges(10);
    end

    $display("[TB] ped request times out");
    base = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    expectAt(base + 7, 5'b00100);
    expectAt(base + 7 + HOLD, 5'b00001);
    waitEdges(20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(10);

    $display("[TB] ped press while phase already served");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitEdges(10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(10);

    $display("[TB] second ped press during REQ is merged");
    base = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    expectAt(base + 7, 5'b00101);
    expectAt(base + 16, 5'b00001);
    waitEdges(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitEdges(7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitEdges(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(10);

    $display("[TB] both inputs pressed together");
    base = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    expectAt(base + 7, 5'b01101);
    waitEdges(8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    expectAt(base + 9, 5'b00101);
    waitEdges(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    expectAt(base + 11, 5'b00001);
    waitEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(10);

    $display("[TB] asynchronous reset while req_side is high");
    base = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectAt(base + 7, 5'b01001);
    waitEdges(8);
    #3;
    monEn = 1'b0;
    RN    = 1'b0;
    #1;
    checkOutput("async_rst_req_side", int'(bus.req_side), 0);
    checkOutput("async_rst_ctl_clr",  int'(bus.ctl_clr),  1);
    checkOutput("async_rst_tmo_ped",  int'(bus.tmo_ped),  0);
    checkOutput("async_rst_req_ped",  int'(bus.req_ped),  0);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #10;
    RN = 1'b1;
    waitEdges(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
